// File: rtl/snoop_bus_controller_pkg.sv
// Shared types for the snooping MSI bus controller: bus FSM states, request classes, word width.
package coherence_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        C2C,
        MEMRD,
        WB,
        INV
    } bus_state_t;

    typedef enum logic [1:0] {
        RC_NONE,
        RC_READ,
        RC_WB,
        RC_UPG
    } req_class_t;

    // A read always wins over a writeback from the same core; upgrade only when neither is asked for.
    function automatic req_class_t classify(input logic ren, input logic wen, input logic ccw);
        if (ren) return RC_READ;
        if (wen) return RC_WB;
        if (ccw) return RC_UPG;
        return RC_NONE;
    endfunction

endpackage

// File: rtl/snoop_bus_controller_if.sv
// Core-side dcache/coherence signals and the shared memory port of the snooping bus.
interface snoop_bus_if #(
    parameter int NCORES = 2
);
    import coherence_pkg::*;

    logic [NCORES-1:0]             dREN;
    logic [NCORES-1:0]             dWEN;
    logic [NCORES-1:0]             cctrans;
    logic [NCORES-1:0]             ccwrite;
    logic [NCORES-1:0][WORD_W-1:0] daddr;
    logic [NCORES-1:0][WORD_W-1:0] dstore;
    logic [NCORES-1:0]             dwait;
    logic [NCORES-1:0][WORD_W-1:0] dload;
    logic [NCORES-1:0]             ccwait;
    logic [NCORES-1:0]             ccinv;
    logic [NCORES-1:0][WORD_W-1:0] ccsnoopaddr;

    logic                          mem_dREN;
    logic                          mem_dWEN;
    logic [WORD_W-1:0]             mem_daddr;
    logic [WORD_W-1:0]             mem_dstore;
    logic [WORD_W-1:0]             mem_dload;
    logic                          mem_dwait;

    modport master (
        input  dREN, dWEN, cctrans, ccwrite, daddr, dstore, mem_dload, mem_dwait,
        output dwait, dload, ccwait, ccinv, ccsnoopaddr,
               mem_dREN, mem_dWEN, mem_daddr, mem_dstore
    );

    modport slave (
        output dREN, dWEN, cctrans, ccwrite, daddr, dstore, mem_dload, mem_dwait,
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr,
               mem_dREN, mem_dWEN, mem_daddr, mem_dstore
    );

endinterface

// File: rtl/snoop_bus_controller_rr_arbiter.sv
// Round-robin pick among N requesters starting at ptr; combinational, one-hot grant plus index.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    int pos;

    // Scan from the far end so the requester closest to ptr is written last and wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        pos = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_controller.sv
// N-core MSI snooping bus: arbitrates dcache misses, snoops, c2c/memory fills, writebacks, upgrades. Optional SNOOP_BUS_STATS_EN adds completion counters.
// One transaction at a time; grant takes one cycle, words complete on mem_dwait=0; stalled cores see dwait=1.
module snoop_bus_controller
    import coherence_pkg::*;
#(
    parameter int NCORES          = 2,
    parameter int WORDS_PER_BLOCK = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    snoop_bus_if.master bus
`ifdef SNOOP_BUS_STATS_EN
    ,
    output logic [WORD_W-1:0] stat_c2c,
    output logic [WORD_W-1:0] stat_memrd,
    output logic [WORD_W-1:0] stat_wb,
    output logic [WORD_W-1:0] stat_inv
`endif
);

    localparam int IDX_W = $clog2(NCORES);
    localparam int CNT_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;

    bus_state_t        state_q, state_d;
    logic [IDX_W-1:0]  req_q, req_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NCORES-1:0] cand;
    logic [NCORES-1:0] arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_vld;
    req_class_t        win_cls;

    logic              snp_all;
    logic [NCORES-1:0] owners;
    logic [IDX_W-1:0]  own_idx;
    logic              word_done;
    logic              last_word;
    logic              xfer_end;
    logic [IDX_W-1:0]  rr_next;

    always_comb begin
        cand = '0;
        for (int i = 0; i < NCORES; i++) begin
            cand[i] = bus.cctrans[i] & (bus.dREN[i] | bus.dWEN[i] | bus.ccwrite[i]);
        end
    end

    rr_arbiter #(.N(NCORES), .IDX_W(IDX_W)) u_arb (
        .req (cand),
        .ptr (rr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    assign win_cls = classify(|(arb_gnt & bus.dREN), |(arb_gnt & bus.dWEN), |(arb_gnt & bus.ccwrite));

    // Lowest-index Modified holder becomes the owner.
    always_comb begin
        snp_all = 1'b1;
        owners  = '0;
        own_idx = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (IDX_W'(i) != req_q) begin
                if (!bus.cctrans[i]) snp_all = 1'b0;
                if (bus.ccwrite[i]) begin
                    owners[i] = 1'b1;
                    own_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign word_done = !bus.mem_dwait;
    assign last_word = (cnt_q == CNT_W'(WORDS_PER_BLOCK - 1));
    assign xfer_end  = word_done && last_word;
    assign rr_next   = (req_q == IDX_W'(NCORES - 1)) ? '0 : req_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    req_d = arb_idx;
                    cnt_d = '0;
                    case (win_cls)
                        RC_READ: state_d = SNOOP;
                        RC_WB:   state_d = WB;
                        RC_UPG:  state_d = INV;
                        default: state_d = IDLE;
                    endcase
                end
            end
            SNOOP: begin
                if (snp_all) begin
                    if (|owners) begin
                        owner_d = own_idx;
                        state_d = C2C;
                    end else begin
                        state_d = MEMRD;
                    end
                end
            end
            C2C, MEMRD, WB: begin
                if (word_done) begin
                    cnt_d = last_word ? '0 : cnt_q + CNT_W'(1);
                    if (last_word) begin
                        state_d = IDLE;
                        rr_d    = rr_next;
                    end
                end
            end
            INV: begin
                state_d = IDLE;
                rr_d    = rr_next;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            req_q   <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by nRST so an abort drops memory strobes in the reset cycle itself.
    always_comb begin
        bus.dwait       = '1;
        bus.dload       = '0;
        bus.ccwait      = '0;
        bus.ccinv       = '0;
        bus.ccsnoopaddr = '0;
        bus.mem_dREN    = 1'b0;
        bus.mem_dWEN    = 1'b0;
        bus.mem_daddr   = '0;
        bus.mem_dstore  = '0;
        if (nRST && state_q != IDLE) begin
            for (int i = 0; i < NCORES; i++) begin
                if (IDX_W'(i) != req_q) begin
                    bus.ccwait[i]      = 1'b1;
                    bus.ccsnoopaddr[i] = bus.daddr[req_q];
                    if (state_q == SNOOP) bus.ccinv[i] = bus.ccwrite[req_q];
                    if (state_q == INV)   bus.ccinv[i] = 1'b1;
                end
            end
            case (state_q)
                C2C: begin
                    bus.mem_dWEN      = 1'b1;
                    bus.mem_daddr     = bus.daddr[owner_q];
                    bus.mem_dstore    = bus.dstore[owner_q];
                    bus.dload[req_q]  = bus.dstore[owner_q];
                    if (word_done) begin
                        bus.dwait[req_q]   = 1'b0;
                        bus.dwait[owner_q] = 1'b0;
                    end
                end
                MEMRD: begin
                    bus.mem_dREN     = 1'b1;
                    bus.mem_daddr    = bus.daddr[req_q];
                    bus.dload[req_q] = bus.mem_dload;
                    bus.dwait[req_q] = bus.mem_dwait;
                end
                WB: begin
                    bus.mem_dWEN     = 1'b1;
                    bus.mem_daddr    = bus.daddr[req_q];
                    bus.mem_dstore   = bus.dstore[req_q];
                    bus.dwait[req_q] = bus.mem_dwait;
                end
                INV: bus.dwait[req_q] = 1'b0;
                default: ;
            endcase
        end
    end

    a_single_owner: assert property (@(posedge CLK) disable iff (!nRST)
        (state_q == SNOOP && snp_all) |-> $onehot0(owners));

`ifdef SNOOP_BUS_STATS_EN
    logic [WORD_W-1:0] stat_c2c_q, stat_c2c_d;
    logic [WORD_W-1:0] stat_memrd_q, stat_memrd_d;
    logic [WORD_W-1:0] stat_wb_q, stat_wb_d;
    logic [WORD_W-1:0] stat_inv_q, stat_inv_d;

    always_comb begin
        stat_c2c_d   = stat_c2c_q   + WORD_W'(state_q == C2C   && xfer_end);
        stat_memrd_d = stat_memrd_q + WORD_W'(state_q == MEMRD && xfer_end);
        stat_wb_d    = stat_wb_q    + WORD_W'(state_q == WB    && xfer_end);
        stat_inv_d   = stat_inv_q   + WORD_W'(state_q == INV);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stat_c2c_q   <= '0;
            stat_memrd_q <= '0;
            stat_wb_q    <= '0;
            stat_inv_q   <= '0;
        end else begin
            stat_c2c_q   <= stat_c2c_d;
            stat_memrd_q <= stat_memrd_d;
            stat_wb_q    <= stat_wb_d;
            stat_inv_q   <= stat_inv_d;
        end
    end

    assign stat_c2c   = stat_c2c_q;
    assign stat_memrd = stat_memrd_q;
    assign stat_wb    = stat_wb_q;
    assign stat_inv   = stat_inv_q;
`else
    logic unused_end;
    assign unused_end = xfer_end;
`endif

endmodule
